// File: rtl/song_selector_if.sv
// Song-select interface: button/enable inputs toward the selector and the
// continuously-read selection outputs back toward gameplay/display.
//   master : drives btn_left, btn_right, enable; reads the selection outputs
//   slave  : the selector itself; reads the inputs, drives the outputs
//   btn_left / btn_right : level buttons, stepped on their rising edge
//   enable               : high while the song-select screen is active
//   selected_song        : one-hot code (0001 / 0010 / 0100)
//   popup_message        : 8 ASCII chars, char 0 (leftmost) in [63:56]
//   bpm_output           : tempo of the selected song
interface song_selector_if;
  logic        btn_left;
  logic        btn_right;
  logic        enable;
  logic [3:0]  selected_song;
  logic [63:0] popup_message;
  logic [15:0] bpm_output;

  modport master (
    output btn_left,
    output btn_right,
    output enable,
    input  selected_song,
    input  popup_message,
    input  bpm_output
  );

  modport slave (
    input  btn_left,
    input  btn_right,
    input  enable,
    output selected_song,
    output popup_message,
    output bpm_output
  );
endinterface

// File: rtl/song_selector.sv
// Song-selection stage. Left/right button presses (rising edges) cycle
// through three songs while enable is high; the chosen song is reported as a
// one-hot code, its BPM and an 8-character ASCII label, all registered
// together so they never disagree.
//   clk  : system clock, all state on the rising edge
//   rst  : synchronous active-high reset, priority over everything
//   bus  : song_selector_if.slave (buttons, enable, selection outputs)
module song_selector #(
  parameter logic [15:0] BPM_SONG1 = 16'd120,
  parameter logic [15:0] BPM_SONG2 = 16'd100,
  parameter logic [15:0] BPM_SONG3 = 16'd140
) (
  input  logic                  clk,
  input  logic                  rst,
  song_selector_if.slave        bus
);

  typedef enum logic [1:0] {
    SelSong1   = 2'd0,
    SelSong2   = 2'd1,
    SelSong3   = 2'd2,
    SelInvalid = 2'd3
  } sel_e;

  localparam logic [63:0] MsgSong1 = 64'h534F_4E47_2031_2020; // "SONG 1  "
  localparam logic [63:0] MsgSong2 = 64'h534F_4E47_2032_2020; // "SONG 2  "
  localparam logic [63:0] MsgSong3 = 64'h534F_4E47_2033_2020; // "SONG 3  "

  sel_e        sel_q, sel_d;
  logic        left_q, left_d;
  logic        right_q, right_d;
  logic [3:0]  song_q, song_d;
  logic [15:0] bpm_q, bpm_d;
  logic [63:0] msg_q, msg_d;

  logic press_left;
  logic press_right;

  // Edge detect: the previous-level registers track the buttons every cycle,
  // even with enable low, so a button already held when enable rises is not
  // seen as a press.
  always_comb begin
    left_d      = bus.btn_left;
    right_d     = bus.btn_right;
    press_left  = bus.btn_left & ~left_q;
    press_right = bus.btn_right & ~right_q;
  end

  // Selection next state.
  always_comb begin
    sel_d = sel_q;
    if (bus.enable) begin
      if (press_right && !press_left) begin
        unique case (sel_q)
          SelSong1: sel_d = SelSong2;
          SelSong2: sel_d = SelSong3;
          SelSong3: sel_d = SelSong1;
          default:  sel_d = SelSong1;
        endcase
      end else if (press_left && !press_right) begin
        unique case (sel_q)
          SelSong1: sel_d = SelSong3;
          SelSong2: sel_d = SelSong1;
          SelSong3: sel_d = SelSong2;
          default:  sel_d = SelSong1;
        endcase
      end
    end
    // An unreachable code recovers to song 1 regardless of enable.
    if (sel_q == SelInvalid) begin
      sel_d = SelSong1;
    end
  end

  // Outputs decode the next selection so they change on the same edge as
  // the index itself (one clock from button to outputs).
  always_comb begin
    song_d = 4'b0001;
    bpm_d  = BPM_SONG1;
    msg_d  = MsgSong1;
    unique case (sel_d)
      SelSong2: begin
        song_d = 4'b0010;
        bpm_d  = BPM_SONG2;
        msg_d  = MsgSong2;
      end
      SelSong3: begin
        song_d = 4'b0100;
        bpm_d  = BPM_SONG3;
        msg_d  = MsgSong3;
      end
      default: begin
        song_d = 4'b0001;
        bpm_d  = BPM_SONG1;
        msg_d  = MsgSong1;
      end
    endcase
  end

  // Edge registers clear to 0 on reset, so a button held through reset
  // produces exactly one press on the first non-reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= SelSong1;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      song_q  <= 4'b0001;
      bpm_q   <= BPM_SONG1;
      msg_q   <= MsgSong1;
    end else begin
      sel_q   <= sel_d;
      left_q  <= left_d;
      right_q <= right_d;
      song_q  <= song_d;
      bpm_q   <= bpm_d;
      msg_q   <= msg_d;
    end
  end

  assign bus.selected_song = song_q;
  assign bus.bpm_output    = bpm_q;
  assign bus.popup_message = msg_q;

endmodule

// File: tb/tb_song_selector.sv
module tb_song_selector;

  typedef struct packed {
    logic [3:0]  song;
    logic [15:0] bpm;
    logic [63:0] msg;
  } exp_t;

  logic clk;
  logic rst;
  song_selector_if bus ();

  song_selector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests;
  int   fails;
  int   cyc;

  function automatic exp_t song_exp(input int n);
    exp_t e;
    case (n)
      2:       e = '{song: 4'b0010, bpm: 16'd100, msg: 64'h534F4E4720322020};
      3:       e = '{song: 4'b0100, bpm: 16'd140, msg: 64'h534F4E4720332020};
      default: e = '{song: 4'b0001, bpm: 16'd120, msg: 64'h534F4E4720312020};
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs at the falling edge; queue what the outputs
  // must show just after the following rising edge.
  task automatic step(input logic r, input logic l, input logic rr, input logic en,
                      input int exp_song);
    @(negedge clk);
    rst           = r;
    bus.btn_left  = l;
    bus.btn_right = rr;
    bus.enable    = en;
    exp_q.push_back(song_exp(exp_song));
  endtask

  task automatic idle(input int n, input int exp_song);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, exp_song);
  endtask

  // Monitor: outputs are continuous, so one expectation is consumed per edge.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        tests++;
        if (bus.selected_song !== e.song) begin
          fails++;
          $display("FAIL cyc%0d selected_song: got %b expected %b", cyc, bus.selected_song,
                   e.song);
        end
        tests++;
        if (bus.bpm_output !== e.bpm) begin
          fails++;
          $display("FAIL cyc%0d bpm_output: got %0d expected %0d", cyc, bus.bpm_output, e.bpm);
        end
        tests++;
        if (bus.popup_message !== e.msg) begin
          fails++;
          $display("FAIL cyc%0d popup_message: got %h expected %h", cyc, bus.popup_message,
                   e.msg);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.enable    = 1'b0;

    // Reset, then quiet enable.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1);
    idle(5, 1);

    // Three right pulses with wrap.
    step(1'b0, 1'b0, 1'b1, 1'b1, 2); idle(1, 2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3); idle(1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1); idle(1, 1);

    // Left pulses wrap backward from song 1.
    step(1'b0, 1'b1, 1'b0, 1'b1, 3); idle(1, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2); idle(1, 2);

    // Back to song 1, then hold right for 20 cycles: one step only.
    step(1'b0, 1'b0, 1'b1, 1'b1, 3); idle(1, 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1); idle(1, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 2);
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 2);
    idle(2, 2);

    // Both buttons rising together: no change.
    step(1'b0, 1'b1, 1'b1, 1'b1, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 2);
    idle(2, 2);

    // Enable low: pulses ignored, outputs hold.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 2);
      step(1'b0, 1'b0, 1'b0, 1'b0, 2);
    end

    // Right already held when enable rises: no press until re-pressed.
    step(1'b0, 1'b0, 1'b1, 1'b0, 2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 2);
    idle(1, 2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 3);
    idle(2, 3);

    // Reset mid-operation from song 3.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1);
    idle(2, 1);

    // Left held across reset: edge register cleared, so one press after release.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 3);
    idle(2, 3);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
